// File: rtl/vec_dot_arbiter_pkg.sv
// Shared types and helpers for the vec_dot arbiter: operand widths, the tag carried
// beside the datapath, and the round-robin pick used by the grant stage.
package vec_arb_pkg;

    localparam int FLOAT_W = 32;
    localparam int VEC_W   = 96;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } arb_tag_t;

    // First set bit of mask at or after ptr, wrapping at 8. Unused high mask bits must be 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] ptr);
        logic [2:0] pick;
        logic [2:0] idx;
        pick = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (mask[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/vec_dot_arbiter_tag_pipe.sv
// Fixed-depth shift register carrying the requester tag in lockstep with the vec_dot pipe.
// Clear drops every valid bit so no stale tag can claim a later result.
module arb_tag_pipe
    import vec_arb_pkg::*;
#(
    parameter int DEPTH = 24
) (
    input  logic     i_clk,
    input  logic     i_clr,
    input  arb_tag_t i_tag,
    output arb_tag_t o_tag
);

    arb_tag_t r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int k = 0; k < DEPTH; k++) r_stage[k].valid <= 1'b0;
        end else begin
            r_stage[0] <= i_tag;
            for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/vec_dot_arbiter.sv
// Round-robin arbiter sharing one pipelined vec_dot among NUM_REQ requesters with per-requester
// credits and tag-steered returns. Define VEC_DOT_ARB_STATS_EN to add grant/stall counters.
module vec_dot_arbiter
    import vec_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DOT_LATENCY  = 24,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*VEC_W-1:0] req_v1,
    input  logic [NUM_REQ*VEC_W-1:0] req_v2,
    output logic [FLOAT_W-1:0]       dot_v1_x,
    output logic [FLOAT_W-1:0]       dot_v1_y,
    output logic [FLOAT_W-1:0]       dot_v1_z,
    output logic [FLOAT_W-1:0]       dot_v2_x,
    output logic [FLOAT_W-1:0]       dot_v2_y,
    output logic [FLOAT_W-1:0]       dot_v2_z,
    output logic                     dot_valid,
    input  logic [FLOAT_W-1:0]       dot_res_data,
    input  logic                     dot_res_valid,
    output logic [FLOAT_W-1:0]       res_data,
    output logic [NUM_REQ-1:0]       res_valid,
    output logic                     err_sticky
`ifdef VEC_DOT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]    stat_grants,
    output logic [31:0]              stat_stall_cycles
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0]      r_inflight [NUM_REQ];
    logic [IDW-1:0]     r_ptr;
    logic [NUM_REQ-1:0] w_elig_p0;
    logic [7:0]         w_mask_p0;
    logic               w_gnt_vld_p0;
    logic [IDW-1:0]     w_gnt_idx_p0;
    logic [VEC_W-1:0]   w_sel_v1_p0;
    logic [VEC_W-1:0]   w_sel_v2_p0;

    // ---- p0: eligibility, round-robin grant, operand select ----
    always_comb begin
        w_elig_p0   = '0;
        w_mask_p0   = '0;
        req_ready   = '0;
        w_sel_v1_p0 = req_v1[VEC_W-1:0];
        w_sel_v2_p0 = req_v2[VEC_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig_p0[i] = req_valid[i] && (r_inflight[i] < CW'(MAX_INFLIGHT));
            w_mask_p0[i] = w_elig_p0[i];
        end
        w_gnt_vld_p0 = |w_elig_p0;
        w_gnt_idx_p0 = IDW'(rr_pick(w_mask_p0, 3'(r_ptr)));
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_gnt_vld_p0 && (w_gnt_idx_p0 == IDW'(i));
            if (w_gnt_idx_p0 == IDW'(i)) begin
                w_sel_v1_p0 = req_v1[i*VEC_W +: VEC_W];
                w_sel_v2_p0 = req_v2[i*VEC_W +: VEC_W];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            r_ptr <= '0;
        else if (w_gnt_vld_p0)
            r_ptr <= (w_gnt_idx_p0 == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx_p0 + IDW'(1);
    end

    // ---- p1: registered issue into vec_dot ----
    logic               r_dot_vld_p1;
    logic [IDW-1:0]     r_dot_id_p1;
    logic [VEC_W-1:0]   r_v1_p1;
    logic [VEC_W-1:0]   r_v2_p1;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_dot_vld_p1 <= 1'b0;
            r_dot_id_p1  <= '0;
            r_v1_p1      <= '0;
            r_v2_p1      <= '0;
        end else begin
            r_dot_vld_p1 <= w_gnt_vld_p0;
            if (w_gnt_vld_p0) begin
                r_dot_id_p1 <= w_gnt_idx_p0;
                r_v1_p1     <= w_sel_v1_p0;
                r_v2_p1     <= w_sel_v2_p0;
            end
        end
    end

    assign dot_valid = r_dot_vld_p1;
    assign dot_v1_x  = r_v1_p1[2*FLOAT_W +: FLOAT_W];
    assign dot_v1_y  = r_v1_p1[FLOAT_W +: FLOAT_W];
    assign dot_v1_z  = r_v1_p1[0 +: FLOAT_W];
    assign dot_v2_x  = r_v2_p1[2*FLOAT_W +: FLOAT_W];
    assign dot_v2_y  = r_v2_p1[FLOAT_W +: FLOAT_W];
    assign dot_v2_z  = r_v2_p1[0 +: FLOAT_W];

    arb_tag_t w_tag_in;
    arb_tag_t w_tag_tail;
    logic     w_clr;

    always_comb begin
        w_tag_in.valid = r_dot_vld_p1;
        w_tag_in.id    = 3'(r_dot_id_p1);
    end
    assign w_clr = !rst_in;

    arb_tag_pipe #(
        .DEPTH (DOT_LATENCY)
    ) u_tag_pipe (
        .i_clk (clk_in),
        .i_clr (w_clr),
        .i_tag (w_tag_in),
        .o_tag (w_tag_tail)
    );

    // ---- p2: result steering, credit return, misalignment flag ----
    logic [NUM_REQ-1:0] w_ret_oh;
    logic [NUM_REQ-1:0] r_res_vld_p2;
    logic [FLOAT_W-1:0] r_res_data_p2;
    logic               r_err;

    always_comb begin
        w_ret_oh = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_ret_oh[i] = w_tag_tail.valid && (w_tag_tail.id == 3'(i));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_res_vld_p2  <= '0;
            r_res_data_p2 <= '0;
            r_err         <= 1'b0;
        end else begin
            r_res_vld_p2 <= dot_res_valid ? w_ret_oh : '0;
            if (dot_res_valid) r_res_data_p2 <= dot_res_data;
            if (dot_res_valid != w_tag_tail.valid) r_err <= 1'b1;
        end
    end

    // A tag reaching the tail returns its credit whether or not a result came with it.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_in)
                r_inflight[i] <= '0;
            else if (req_ready[i] && !w_ret_oh[i])
                r_inflight[i] <= r_inflight[i] + CW'(1);
            else if (!req_ready[i] && w_ret_oh[i])
                r_inflight[i] <= r_inflight[i] - CW'(1);
        end
    end

    assign res_valid  = r_res_vld_p2;
    assign res_data   = r_res_data_p2;
    assign err_sticky = r_err;

`ifdef VEC_DOT_ARB_STATS_EN
    logic [31:0] r_stat_grants [NUM_REQ];
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REQ; i++) r_stat_grants[i] <= '0;
            r_stat_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i]) r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
            if ((|req_valid) && !w_gnt_vld_p0) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_grants[i*32 +: 32] = r_stat_grants[i];
    end
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: doc/vec_dot_arbiter.md
Name: vec_dot_arbiter

Overview:
- Shares one pipelined vec_dot unit (3 mults, 2 adds, fixed latency) among NUM_REQ requesters: shader, intersect and normalize stages.
- Round-robin arbitration, one issue per cycle, per-requester in-flight credits.
- Carries a requester tag alongside the datapath in a shift register and steers each result back to its owner.
- Sits between the ray-pipeline stages and the single vec_dot instance; drives that instance through ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DOT_LATENCY, 24, cycles from dot_valid to dot_res_valid of the attached vec_dot; the tag pipe depth.
- MAX_INFLIGHT, 8, per-requester outstanding-operation limit (1..2^CW-1).
- Derived: IDW = $clog2(NUM_REQ); CW = $clog2(MAX_INFLIGHT+1).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; a beat transfers on valid&ready.
- req_v1  in  NUM_REQ*96  per requester {x,y,z} float32, requester i at bits [96i+95:96i].
- req_v2  in  NUM_REQ*96  second operand, same packing.
- dot_v1_x/y/z, dot_v2_x/y/z  out  32 each  operands to vec_dot.
- dot_valid  out  1  vec_dot input valid.
- dot_res_data  in  32  vec_dot result.
- dot_res_valid  in  1  vec_dot result valid.
- res_data  out  32  result to requesters (broadcast).
- res_valid  out  NUM_REQ  one-hot owner strobe.
- err_sticky  out  1  tag/result misalignment detected.

Behaviour:
- Reset (rst_in=0 at a clock edge): dot_valid=0; dot operands=0; res_valid=0; res_data=0; err_sticky=0; RR pointer=0; all credit counters=0; tag pipe valid bits=0.
- Eligibility: requester i is eligible when req_valid[i]=1 and inflight[i] < MAX_INFLIGHT.
- Grant: exactly one eligible requester is granted per cycle, the first eligible at or after the RR pointer, modulo NUM_REQ.
  - req_ready is combinational and one-hot: req_ready[i]=1 only for the granted requester.
  - req_ready may depend on req_valid.
  - No eligible requester: req_ready=0.
- RR pointer: after a grant to requester g, pointer <= (g+1) mod NUM_REQ. Otherwise the pointer holds.
- Issue: the cycle after a grant, the dot_* operands are registered from the granted requester and dot_valid=1 for exactly that cycle. Otherwise dot_valid=0 and the operands hold their last value.
- Tag pipe: {valid, id[IDW-1:0]} enters with dot_valid and shifts DOT_LATENCY stages. The tail aligns with dot_res_valid.
- Return: on dot_res_valid, the next cycle res_data=dot_res_data and res_valid=onehot(tail id) for one cycle.
  - Requesters must always accept results; there is no result backpressure.
- Total latency: grant cycle to res_valid = DOT_LATENCY+2 cycles.
- Credits:
  - inflight[i] increments on grant to i.
  - inflight[i] decrements on return to i.
  - Grant and return to the same i in one cycle: net unchanged.
  - Counters never wrap; the eligibility rule prevents overflow.
- Misalignment: dot_res_valid != tail valid sets err_sticky (cleared only by reset).
  - Result with no valid tag: dropped, res_valid stays 0.
  - Valid tag with no result: tag discarded, credit still returned.
- Reset mid-operation: all tags and credits are cleared. The vec_dot instance shares this reset, so its in-flight results vanish too. No res_valid may be produced for pre-reset issues.

Optional Feature:
- VEC_DOT_ARB_STATS_EN defined:
  - Adds output stat_grants, width NUM_REQ*32: free-running per-requester grant counters, wrapping at 2^32, reset to 0.
  - Adds output stat_stall_cycles, 32 bits: counts cycles with any req_valid=1 and no grant.
- Not defined: both ports are absent and no counter logic exists.

Decomposition:
- Package vec_arb_pkg holds:
  - localparam FLOAT_W=32, VEC_W=96;
  - typedef struct packed {logic valid; logic [2:0] id;} arb_tag_t, with id sized for NUM_REQ<=8;
  - function rr_pick(mask, ptr) returning the grant index.
- One natural sub-module: arb_tag_pipe (parameterised depth-DOT_LATENCY shift register of arb_tag_t with synchronous clear).
- Top contains the arbiter, credits, operand mux and return steering.

Test Plan:
- Single requester: req0 v1=(1,2,3), v2=(4,5,6) floats; behavioural vec_dot model. Expect res_valid=4'b0001 with res_data=0x42000000 (32.0) exactly DOT_LATENCY+2 cycles after grant.
- All four requesters valid continuously from reset. Expect grant order 0,1,2,3,0,…, dot_valid every cycle, each result strobed to the correct owner in issue order.
- req1 holds valid with model results stalled, DOT_LATENCY=24 > MAX_INFLIGHT=8. Expect req_ready[1] to drop after 8 grants and reassert the cycle after the first return to req1.
- Same-cycle grant and return to req2 with inflight[2]=MAX_INFLIGHT-1. Expect inflight unchanged and req_ready[2] still asserted.
- Inject a spurious dot_res_valid with an empty tag pipe. Expect err_sticky=1, no res_valid; err_sticky persists until rst_in=0.
- Assert rst_in=0 for 1 cycle with 5 operations in flight. Expect no res_valid for them, all credits 0, RR pointer 0, next grant to the lowest eligible index.
